fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage. Keeps the fetch PC and issues word reads to instruction memory through a req/ready handshake. Buffers returned words in a 2-entry queue and presents the head instruction, with its address, to the combinational control unit in the next stage. Jump redirects from the control unit flush the queue and any in-flight fetch, then restart fetching at the computed target.

## Interface

- RESET_PC, 32'h0000_0000, first fetch address after reset; must be word aligned.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  a read request is presented.
- imem_addr  out  32  request word address; bits [1:0] always 2'b00.
- imem_ready  in  1  the current request completes this cycle.
- imem_rdata  in  32  read data; valid only when imem_req && imem_ready.
- instr  out  32  head-of-queue instruction word, fed to the decoder.
- instr_pc  out  32  address of instr.
- instr_valid  out  1  instr/instr_pc are valid.
- stall  in  1  downstream cannot accept the head this cycle.
- jump_en  in  1  decoder reports that the head is a taken jump.
- jump_addr  in  32  sign-extended word offset for the jump, from the decoder.

## Operation

- Reset values: imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, queue count=0, discard=0.
- Handshake: once imem_req is high, imem_addr stays stable until a cycle with imem_ready=1. That cycle is the completion. At most one request is outstanding.
- Push: on completion without discard, {imem_rdata, imem_addr} is written to the queue tail. Fetch address then becomes imem_addr+4, mod 2^32 (0xFFFF_FFFC wraps to 0).
- Pop/consume: occurs when instr_valid && !stall. The queue head advances.
- Issue rule, evaluated at each edge where no request remains outstanding after that edge:
  - next_count = count + push − pop.
  - imem_req is asserted next cycle iff next_count < 2.
  - This guarantees count + outstanding ≤ 2, so a push can never overflow the queue.
- Jump:
  - jump_en is honoured only in a consume cycle.
  - jump_en while stalled or invalid is ignored.
  - target = instr_pc + (jump_addr << 2), mod 2^32.
  - On a jump, the queue is flushed (count=0, instr_valid=0 next cycle) and target becomes the next fetch address.
- In-flight request at the jump:
  - If the request completes in the same cycle, its data is dropped and target is requested next cycle.
  - Otherwise discard=1 and imem_req/imem_addr are held. The completing response is dropped, discard clears, and target is requested the cycle after.
- Push and pop in the same cycle keep count unchanged. With count=1, the new entry becomes head immediately after the edge.
- Outputs instr/instr_pc/instr_valid are the registered queue head. They do not change while stall=1 and no jump is taken.

## Timing

- Reset → first imem_req=1 with imem_addr=RESET_PC: the first rising edge after rst deasserts.
- Fetch latency: completion at edge N → instr_valid=1 with that word after edge N (when the queue was empty).
- Throughput with zero-wait memory and stall=0: one instruction per cycle, steady state.
- Jump penalty: consume cycle with jump_en at edge N, no request in flight → imem_addr=target after edge N. First target instruction is valid after the completing edge.
- Queue full (count=2) and stall=1: imem_req=0 until a pop.
- Async reset mid-request: imem_req drops immediately and the request is abandoned. Memory must tolerate an abandoned request.

## Test plan

- Reset, RESET_PC=0x100, imem_ready tied 1, stall=0 → imem_addr 0x100, 0x104, 0x108 on consecutive cycles. instr_pc follows one cycle later, instr_valid continuous.
- stall=1 held for 4 cycles after 0x104 is valid → queue fills (0x104, 0x108). imem_req=0 after the second push. instr unchanged. Releasing stall resumes at 0x10C.
- imem_ready asserted 3 cycles after each request → imem_addr stable for all 4 cycles of each request. One instruction delivered per 4 cycles.
- Jump at instr_pc=0x008 with jump_addr=0xFFFF_FFFE → next request 0x000. Queued 0x00C is flushed and never presented.
- Jump while request to 0x20 is outstanding (ready 2 cycles late) → 0x20 stays on imem_addr until ready. Its data is dropped, then target requested. instr_valid=0 throughout.
- rst pulsed mid-request and mid-stall → all outputs at reset values immediately. Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory handshake and the decode-side
// signals of the fetch stage.
//   master : fetch_unit side (drives imem_req/imem_addr and the instr head)
//   slave  : memory + decoder side (drives imem_ready/imem_rdata, stall, jump)
interface fetch_unit_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            stall;
  logic            jump_en;
  logic [XLEN-1:0] jump_addr;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid,
    input  imem_ready, imem_rdata, stall, jump_en, jump_addr
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid,
    output imem_ready, imem_rdata, stall, jump_en, jump_addr
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Keeps the fetch PC, issues one-at-a-time word reads over a req/ready
// handshake, buffers returned words in a 2-entry queue and presents the
// registered queue head to the decoder. A taken jump in a consume cycle
// flushes the queue and any in-flight fetch and restarts at the target.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - fetch_unit_if.master (imem req/addr/ready/rdata, instr/instr_pc/
//          instr_valid, stall, jump_en/jump_addr)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 2;

  // RUN: responses are accepted; DISCARD: the outstanding response is dropped
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  logic [0:0]      state_q,   state_d;
  logic            req_q,     req_d;
  logic [XLEN-1:0] addr_q,    addr_d;
  logic [XLEN-1:0] target_q,  target_d;
  logic [CW-1:0]   count_q,   count_d;
  logic            valid_q,   valid_d;
  logic [XLEN-1:0] e0_data_q, e0_data_d;
  logic [XLEN-1:0] e0_pc_q,   e0_pc_d;
  logic [XLEN-1:0] e1_data_q, e1_data_d;
  logic [XLEN-1:0] e1_pc_q,   e1_pc_d;

  logic            completion_c;
  logic            pending_c;
  logic            consume_c;
  logic            jump_c;
  logic            push_c;
  logic            pop_c;
  logic [XLEN-1:0] jump_target_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      target_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      e0_data_q <= '0;
      e0_pc_q   <= '0;
      e1_data_q <= '0;
      e1_pc_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      target_q  <= target_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      e0_data_q <= e0_data_d;
      e0_pc_q   <= e0_pc_d;
      e1_data_q <= e1_data_d;
      e1_pc_q   <= e1_pc_d;
    end
  end

  // Next-state: handshake, queue update, jump/flush handling
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    target_d  = target_q;
    count_d   = count_q;
    valid_d   = valid_q;
    e0_data_d = e0_data_q;
    e0_pc_d   = e0_pc_q;
    e1_data_d = e1_data_q;
    e1_pc_d   = e1_pc_q;

    completion_c  = req_q && bus.imem_ready;
    pending_c     = req_q && !bus.imem_ready;
    consume_c     = valid_q && !bus.stall;
    jump_c        = consume_c && bus.jump_en;
    push_c        = completion_c && (state_q == ST_RUN) && !jump_c;
    pop_c         = consume_c && !jump_c;
    jump_target_c = e0_pc_q + (bus.jump_addr << 2);

    if (jump_c) begin
      count_d = '0;
      valid_d = 1'b0;
      if (pending_c) begin
        // Request must stay stable until it completes; remember the target
        state_d  = ST_DISCARD;
        target_d = jump_target_c;
      end else begin
        state_d = ST_RUN;
        addr_d  = jump_target_c;
        req_d   = 1'b1;
      end
    end else begin
      unique case ({push_c, pop_c})
        2'b11: begin
          if (count_q == CW'(2)) begin
            e0_data_d = e1_data_q;
            e0_pc_d   = e1_pc_q;
            e1_data_d = bus.imem_rdata;
            e1_pc_d   = addr_q;
          end else begin
            e0_data_d = bus.imem_rdata;
            e0_pc_d   = addr_q;
          end
        end
        2'b01: begin
          e0_data_d = e1_data_q;
          e0_pc_d   = e1_pc_q;
          count_d   = count_q - CW'(1);
        end
        2'b10: begin
          if (count_q == CW'(0)) begin
            e0_data_d = bus.imem_rdata;
            e0_pc_d   = addr_q;
          end else begin
            e1_data_d = bus.imem_rdata;
            e1_pc_d   = addr_q;
          end
          count_d = count_q + CW'(1);
        end
        default: ;
      endcase
      valid_d = (count_d != CW'(0));

      if (completion_c) begin
        if (state_q == ST_DISCARD) begin
          state_d = ST_RUN;
          addr_d  = target_q;
        end else begin
          addr_d = addr_q + 32'd4;
        end
      end

      // Issue only with no request outstanding; keeps count+outstanding <= 2
      if (!pending_c) begin
        req_d = (count_d < CW'(2));
      end
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr       = e0_data_q;
  assign bus.instr_pc    = e0_pc_q;
  assign bus.instr_valid = valid_q;

endmodule
